// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NCH independent run-time programmable clock dividers, each with a
// one-cycle tick and a 50% square wave, plus global enable, phase clear and write-error pulse.
module tick_gen_multi #(
    parameter int CNT_W   = 28,
    parameter int NCH     = 2,
    parameter int CH_W    = 4,
    parameter int DEF_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq,
    output logic             cfg_err
);
    if (DEF_DIV < 2 || (64'(DEF_DIV) >> CNT_W) != 0 || (64'(1) << CH_W) < 64'(NCH) || NCH < 1 || NCH > 16)
    begin : g_bad_params
        $error("tick_gen_multi: illegal parameter set");
    end
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [CNT_W-1:0] div_q [NCH];
    logic [CNT_W-1:0] div_d [NCH];
    logic [NCH-1:0]   tick_q, tick_d, sq_q, sq_d, wr, wrap;
    logic             err_q, err_d, accept;
    always_comb begin
        accept = cfg_we && cfg_div >= CNT_W'(2) && 32'(cfg_ch) < NCH;
        err_d  = cfg_we && !accept;
        for (int c = 0; c < NCH; c++) begin
            wr[c]     = accept && cfg_ch == CH_W'(c);
            wrap[c]   = cnt_q[c] == div_q[c] - CNT_W'(1);
            cnt_d[c]  = (sync_clr || wr[c] || (en && wrap[c])) ? '0 : en ? cnt_q[c] + CNT_W'(1) : cnt_q[c];
            div_d[c]  = wr[c] ? cfg_div : div_q[c];
            tick_d[c] = !sync_clr && !wr[c] && en && wrap[c];
            // a write restarts the count but keeps the square-wave level
            sq_d[c]   = sync_clr ? 1'b0 : tick_d[c] ? ~sq_q[c] : sq_q[c];
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
                div_q[c] <= CNT_W'(DEF_DIV);
            end
            tick_q <= '0;
            sq_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
            err_q  <= err_d;
        end
    end
    assign tick    = tick_q;
    assign sq      = sq_q;
    assign cfg_err = err_q;
endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed and random stimulus; expected outputs come from an
// enabled-cycle-count model and are queued for a monitor that compares after each edge.
module tb_tick_gen_multi;
    localparam int CNT_W = 28, NCH = 2, CH_W = 4, DEF_DIV = 10;
    logic clk = 1'b0, rst = 1'b0, en = 1'b0, sync_clr = 1'b0, cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic [NCH-1:0]   tick, sq;
    logic             cfg_err;
    logic             rst_v = 1'b0;
    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
        logic           err;
    } exp_t;
    exp_t q[$];
    int vectors = 0, miscompares = 0;
    int m_e [NCH];
    int m_div [NCH];
    logic m_sqb [NCH];

    tick_gen_multi #(.CNT_W(CNT_W), .NCH(NCH), .CH_W(CH_W), .DEF_DIV(DEF_DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .tick(tick), .sq(sq), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic cur_sq(input int c);
        return m_sqb[c] ^ (((m_e[c] / m_div[c]) % 2) == 1);
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_e[c] = 0;
            m_div[c] = DEF_DIV;
            m_sqb[c] = 1'b0;
        end
    endfunction

    // m_e counts enabled edges since the last restart; ticks land on its multiples of div
    task automatic step(input logic en_v, input logic clr_v, input logic we_v, input int ch_v, input int div_v);
        exp_t x;
        logic ok, wr;
        @(negedge clk);
        rst = rst_v; en = en_v; sync_clr = clr_v; cfg_we = we_v;
        cfg_ch = CH_W'(ch_v); cfg_div = CNT_W'(div_v);
        x = '0;
        if (!rst_v) model_reset();
        else begin
            ok = we_v && div_v >= 2 && ch_v < NCH;
            x.err = we_v && !ok;
            for (int c = 0; c < NCH; c++) begin
                wr = ok && ch_v == c;
                if (clr_v) begin
                    m_e[c] = 0;
                    m_sqb[c] = 1'b0;
                end else if (wr) begin
                    m_sqb[c] = cur_sq(c);
                    m_e[c] = 0;
                end else if (en_v) begin
                    m_e[c]++;
                    x.tick[c] = (m_e[c] % m_div[c]) == 0;
                end
                if (wr) m_div[c] = div_v;
                x.sq[c] = cur_sq(c);
            end
        end
        q.push_back(x);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        rst_v = 1'b0;
        #1;
        check("async_tick", 32'(tick), 32'd0);
        check("async_sq", 32'(sq), 32'd0);
        check("async_err", 32'(cfg_err), 32'd0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 0, 0);
        rst_v = 1'b1;
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("tick", 32'(tick), 32'(x.tick));
                check("sq", 32'(sq), 32'(x.sq));
                check("cfg_err", 32'(cfg_err), 32'(x.err));
            end
        end
    end

    initial begin
        model_reset();
        #1;
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_sq", 32'(sq), 32'd0);
        check("reset_err", 32'(cfg_err), 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 0, 0);
        rst_v = 1'b1;
        for (int i = 1; i <= 45; i++) step(1'b1, 1'b0, i == 5, 1, 19);
        step(1'b1, 1'b0, 1'b1, 0, 1);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b1, 3, 12);
        step(1'b1, 1'b0, 1'b1, 1, 0);
        repeat (30) step(1'b1, 1'b0, 1'b0, 0, 0);
        repeat (7) step(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (30) step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        repeat (40) step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 0, 4);
        repeat (10) step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1, 3);
        repeat (3) step(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b1, 0, 2);
        repeat (6) step(1'b1, 1'b0, 1'b0, 0, 0);
        async_reset();
        repeat (25) step(1'b1, 1'b0, 1'b0, 0, 0);
        repeat (3000) begin
            if ($urandom % 600 == 0) async_reset();
            step($urandom % 8 != 0, $urandom % 64 == 0, $urandom % 16 == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 24)));
        end
        repeat (2) @(posedge clk);
        #3;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
